// File: rtl/boot_patch_loader.sv
// rtl/boot_patch_loader.sv - serial boot-stream to word-store patch loader
// Assembles MSB-first bits into words and writes each with a cs/we/addr/din handshake.
module boot_patch_loader #(
  parameter logic [3:0] BASE_ADDR = 4'h7,
  parameter int         NUM_WORDS = 4,
  parameter int         WORD_W    = 16
) (
  input  logic              clk8th,
  input  logic              rst,
  input  logic              start,
  input  logic              sdi,
  input  logic              sdi_valid,
  output logic              cs,
  output logic              we,
  output logic [3:0]        addr,
  output logic [WORD_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [4:0]        word_cnt, word_cnt_nxt;
  logic [WORD_W-1:0] hold, hold_nxt;
  logic              pending, pending_nxt;
  logic              cs_nxt, we_nxt, busy_nxt, done_nxt, overrun_nxt;
  logic [3:0]        addr_nxt;
  logic [WORD_W-1:0] din_nxt;
  logic [WORD_W-1:0] shift_word;
  logic              word_done;
  logic              take;

  assign word_done = busy && sdi_valid && (bit_cnt == BW'(WORD_W - 1));
  assign take      = (state == S_LOAD) && pending;

  always_ff @(posedge clk8th or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      hold     <= '0;
      pending  <= 1'b0;
      cs       <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      din      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      hold     <= hold_nxt;
      pending  <= pending_nxt;
      cs       <= cs_nxt;
      we       <= we_nxt;
      addr     <= addr_nxt;
      din      <= din_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      overrun  <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;
    hold_nxt     = hold;
    pending_nxt  = pending;
    cs_nxt       = cs;
    we_nxt       = we;
    addr_nxt     = addr;
    din_nxt      = din;
    busy_nxt     = busy;
    done_nxt     = done;
    overrun_nxt  = overrun;
    shift_word   = shreg << 1;
    shift_word[0] = sdi;

    if (busy && sdi_valid) begin
      shreg_nxt   = shift_word;
      bit_cnt_nxt = word_done ? '0 : bit_cnt + 1'b1;
    end

    if (take)
      pending_nxt = 1'b0;

    // A word landing in the same cycle its predecessor is consumed is not an overrun.
    if (word_done) begin
      hold_nxt    = shift_word;
      pending_nxt = 1'b1;
      if (pending && !take)
        overrun_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_LOAD;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          overrun_nxt  = 1'b0;
          word_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          shreg_nxt    = '0;
          pending_nxt  = 1'b0;
        end
      end
      S_LOAD: begin
        if (pending) begin
          state_nxt = S_SETUP;
          addr_nxt  = BASE_ADDR + word_cnt[3:0];
          din_nxt   = hold;
          cs_nxt    = 1'b1;
          we_nxt    = 1'b0;
        end
      end
      S_SETUP: begin
        state_nxt = S_WRITE;
        we_nxt    = 1'b1;
      end
      S_WRITE: begin
        state_nxt = S_HOLD;
        we_nxt    = 1'b0;
      end
      S_HOLD: begin
        cs_nxt       = 1'b0;
        word_cnt_nxt = word_cnt + 5'd1;
        if (word_cnt_nxt == 5'(NUM_WORDS)) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cs_nxt    = 1'b0;
        we_nxt    = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_boot_patch_loader.sv
// tb/tb_boot_patch_loader.sv - randomized bench for boot_patch_loader
// Three builds: default, wrapping base address, and a 1-bit word build that overruns.
module tb_boot_patch_loader;

  logic clk8th = 1'b0;
  logic rst;
  logic start;
  logic sdi;
  logic sdi_valid;
  int   sel;

  logic        cs_n, we_n, busy_n, done_n, ovr_n;
  logic [3:0]  addr_n;
  logic [15:0] din_n;
  logic        cs_w, we_w, busy_w, done_w, ovr_w;
  logic [3:0]  addr_w;
  logic [15:0] din_w;
  logic        cs_o, we_o, busy_o, done_o, ovr_o;
  logic [3:0]  addr_o;
  logic [0:0]  din_o;

  logic        cs_s, we_s, busy_s, done_s, ovr_s;
  logic [3:0]  addr_s;
  logic [15:0] din_s;

  logic start_n, start_w, start_o;
  assign start_n = start && (sel == 0);
  assign start_w = start && (sel == 1);
  assign start_o = start && (sel == 2);

  boot_patch_loader u_nom (
    .clk8th(clk8th), .rst(rst), .start(start_n), .sdi(sdi), .sdi_valid(sdi_valid),
    .cs(cs_n), .we(we_n), .addr(addr_n), .din(din_n),
    .busy(busy_n), .done(done_n), .overrun(ovr_n)
  );

  boot_patch_loader #(.BASE_ADDR(4'hE), .NUM_WORDS(3), .WORD_W(16)) u_wrap (
    .clk8th(clk8th), .rst(rst), .start(start_w), .sdi(sdi), .sdi_valid(sdi_valid),
    .cs(cs_w), .we(we_w), .addr(addr_w), .din(din_w),
    .busy(busy_w), .done(done_w), .overrun(ovr_w)
  );

  boot_patch_loader #(.BASE_ADDR(4'h7), .NUM_WORDS(4), .WORD_W(1)) u_ovr (
    .clk8th(clk8th), .rst(rst), .start(start_o), .sdi(sdi), .sdi_valid(sdi_valid),
    .cs(cs_o), .we(we_o), .addr(addr_o), .din(din_o),
    .busy(busy_o), .done(done_o), .overrun(ovr_o)
  );

  always_comb begin
    case (sel)
      1: {cs_s, we_s, addr_s, din_s, busy_s, done_s, ovr_s} =
           {cs_w, we_w, addr_w, din_w, busy_w, done_w, ovr_w};
      2: {cs_s, we_s, addr_s, din_s, busy_s, done_s, ovr_s} =
           {cs_o, we_o, addr_o, 15'b0, din_o, busy_o, done_o, ovr_o};
      default: {cs_s, we_s, addr_s, din_s, busy_s, done_s, ovr_s} =
           {cs_n, we_n, addr_n, din_n, busy_n, done_n, ovr_n};
    endcase
  end

  always #5 clk8th = ~clk8th;

  int cyc = 0;
  always @(posedge clk8th) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor on the selected instance
  int          start_cyc = 0;
  bit          mon_en = 1'b0;
  bit          rise = 1'b0;
  logic        cs_p = 1'b0, we_p = 1'b0;
  logic [3:0]  addr_p = '0;
  logic [15:0] din_p = '0;
  int          mon_addr[$];
  int          mon_din[$];
  int          mon_edge[$];

  always @(negedge clk8th) begin
    if (mon_en && !rst) begin
      if (we_s && !we_p) begin
        mon_addr.push_back(int'(addr_s));
        mon_din.push_back(int'(din_s));
        mon_edge.push_back(cyc - start_cyc);
        chk("cs_at_we", cs_s, 1);
        chk("setup_stable", {cs_p, addr_p == addr_s, din_p == din_s}, 3'b111);
        rise = 1'b1;
      end else if (rise) begin
        rise = 1'b0;
        chk("we_width", we_s, 0);
        chk("hold_stable", {cs_s, addr_p == addr_s, din_p == din_s}, 3'b111);
      end
      if (addr_s != addr_p)
        chk("addr_move_under_cs", cs_p, 0);
    end
    cs_p   = cs_s;
    we_p   = we_s;
    addr_p = addr_s;
    din_p  = din_s;
  end

  // Stimulus and reference model
  bit stim_v[$];
  bit stim_b[$];
  int wq[$];
  int exp_addr[$];
  int exp_din[$];
  int exp_edge[$];
  bit exp_ovr;
  int k_last;

  function automatic int base_of(input int s); return (s == 1) ? 14 : 7; endfunction
  function automatic int num_of(input int s);  return (s == 1) ? 3 : 4;  endfunction
  function automatic int w_of(input int s);    return (s == 2) ? 1 : 16; endfunction

  task automatic gen(input int w, input int gapmode);
    int idle;
    stim_v.delete();
    stim_b.delete();
    foreach (wq[i]) begin
      for (int b = w - 1; b >= 0; b--) begin
        idle = (gapmode == 1) ? 4 : (gapmode == 2) ? int'($urandom_range(0, 3)) : 0;
        for (int g = 0; g < idle; g++) begin
          stim_v.push_back(1'b0);
          stim_b.push_back(1'($urandom));
        end
        stim_v.push_back(1'b1);
        stim_b.push_back(1'((wq[i] >> b) & 1));
      end
    end
  endtask

  // A single holding slot served by a writer that needs 4 cycles per word;
  // a word landing on a still-occupied slot replaces it and flags overrun.
  task automatic model_run(input int base, input int n, input int w);
    int L = stim_v.size();
    bit pend = 1'b0;
    int pword = 0, nt = 1, taken = 0, cnt = 0, acc = 0;
    int mask = (1 << w) - 1;
    exp_addr.delete();
    exp_din.delete();
    exp_edge.delete();
    exp_ovr = 1'b0;
    k_last = -1;
    for (int k = 1; k <= L + 4 * n + 8; k++) begin
      if (k_last >= 0 && k > k_last + 3) break;
      if (taken < n && pend && k >= nt) begin
        exp_addr.push_back((base + taken) % 16);
        exp_din.push_back(pword);
        exp_edge.push_back(k + 1);
        taken++;
        nt = k + 4;
        pend = 1'b0;
        if (taken == n) k_last = k;
      end
      if (k - 1 < L && stim_v[k-1]) begin
        acc = ((acc << 1) | int'(stim_b[k-1])) & mask;
        cnt++;
        if (cnt == w) begin
          cnt = 0;
          if (pend) exp_ovr = 1'b1;
          pword = acc;
          pend = 1'b1;
        end
      end
    end
  endtask

  task automatic run_load(input int s, input bit spur, input bit gapchk);
    int L, kd, kend;
    model_run(base_of(s), num_of(s), w_of(s));
    L = stim_v.size();
    if (k_last < 0) k_last = L;
    kd = k_last + 3;
    kend = ((L > kd) ? L : kd) + 3;
    sel = s;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk8th);
      sdi_valid = 1'b1;
      sdi = 1'($urandom);
    end
    @(negedge clk8th);
    start = 1'b1;
    sdi_valid = 1'b1;
    sdi = 1'($urandom);
    mon_addr.delete();
    mon_din.delete();
    mon_edge.delete();
    @(posedge clk8th);
    #1;
    start_cyc = cyc;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk8th);
      start = spur && (k == 5);
      if (k - 1 < L) begin
        sdi_valid = stim_v[k-1];
        sdi = stim_b[k-1];
      end else begin
        sdi_valid = 1'b0;
        sdi = 1'b0;
      end
      @(posedge clk8th);
      #1;
      if (k == 1)      chk("started_busy_done", {busy_s, done_s}, 2'b10);
      if (k == kd - 1) chk("busy_before_done", busy_s, 1);
      if (k == kd)     chk("done_after_hold", {busy_s, done_s}, 2'b01);
      if (k == kd + 2) chk("done_sticky", {busy_s, done_s}, 2'b01);
    end
    @(negedge clk8th);
    start = 1'b0;
    sdi_valid = 1'b0;
    chk("n_writes", mon_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) begin
      if (i < mon_addr.size()) begin
        chk("wr_addr", mon_addr[i], exp_addr[i]);
        chk("wr_data", mon_din[i], exp_din[i]);
        chk("wr_edge", mon_edge[i], exp_edge[i]);
      end
    end
    chk("overrun", ovr_s, exp_ovr);
    if (gapchk)
      for (int i = 1; i < mon_edge.size(); i++)
        chk("we_spacing", mon_edge[i] - mon_edge[i-1] >= 76, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sdi = 1'b0;
    sdi_valid = 1'b0;
    sel = 0;
    #1;
    chk("reset_nom", {cs_n, we_n, addr_n, din_n, busy_n, done_n, ovr_n}, 0);
    chk("reset_wrap", {cs_w, we_w, addr_w, din_w, busy_w, done_w, ovr_w}, 0);
    @(negedge clk8th);
    @(negedge clk8th);
    rst = 1'b0;
    mon_en = 1'b1;

    wq = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};
    gen(16, 0);
    run_load(0, 1'b1, 1'b0);

    gen(16, 1);
    run_load(0, 1'b0, 1'b1);

    for (int r = 0; r < 2; r++) begin
      wq.delete();
      for (int i = 0; i < 4; i++) wq.push_back(int'($urandom_range(0, 65535)));
      gen(16, 2);
      run_load(0, 1'b0, 1'b0);
    end

    wq = '{16'h1111, 16'h2222, 16'h3333};
    gen(16, 0);
    run_load(1, 1'b0, 1'b0);

    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back(int'($urandom_range(0, 1)));
    gen(1, 0);
    run_load(2, 1'b1, 1'b0);

    // Abandon a load mid-write with an asynchronous reset
    sel = 0;
    wq = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    gen(16, 0);
    @(negedge clk8th);
    start = 1'b1;
    @(negedge clk8th);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      sdi_valid = stim_v[k % stim_v.size()];
      sdi = stim_b[k % stim_v.size()];
      @(negedge clk8th);
      if (we_s) break;
    end
    chk("we_seen_before_reset", we_s, 1);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_mid_write", {cs_s, we_s, addr_s, din_s, busy_s, done_s, ovr_s}, 0);
    sdi_valid = 1'b0;
    @(negedge clk8th);
    rst = 1'b0;
    rise = 1'b0;
    @(negedge clk8th);
    mon_en = 1'b1;
    chk("idle_after_reset", {busy_s, done_s, cs_s}, 0);

    wq = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};
    gen(16, 0);
    run_load(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_patch_loader.md
Name: boot_patch_loader

Overview:
- Upstream feeder for the boot ROM/RAM word store; fills its writable words (default addresses 7..A) from a bit-serial boot stream before the CPU is released.
- Assembles MSB-first serial bits into 16-bit words and issues one glitch-free write transaction per word on the store's cs/we/addr/din port.
- Supports patching the boot vector word (7) and scratch words (8..A) from an external SPI-style source, then reports done or overrun.

Parameters:
- BASE_ADDR, 4'h7, first store address written.
- NUM_WORDS, 4, words per load; range 1..16.
- WORD_W, 16, data word width.

Ports:
- clk8th  in  1  block clock; all flops rise on posedge clk8th.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- sdi  in  1  serial data bit, MSB first.
- sdi_valid  in  1  sdi is sampled on any clock edge where this is high.
- cs  out  1  store chip select.
- we  out  1  store write enable.
- addr  out  4  store word address.
- din  out  WORD_W  store write data.
- busy  out  1  high from accepted start until DONE.
- done  out  1  sticky; set at end of a load, cleared by the next accepted start.
- overrun  out  1  sticky; word completed while the previous word was still pending.

Behaviour:
- Reset (async, immediate): state IDLE; cs=0, we=0, addr=0, din=0; busy=0, done=0, overrun=0; shift register, bit counter and word counter cleared; pending flag=0.
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.
- Shifter: 16-bit shift register plus 4-bit bit counter, active only while busy.
  - Each sdi_valid cycle: shift left, insert sdi at bit 0, increment the bit counter.
  - On the 16th bit: copy the word to the holding register, set pending, reset the bit counter to 0.
  - Shifting continues through all write phases.
- Overrun: if a word completes while pending=1, set overrun, overwrite the holding register, and keep pending=1. The lost word is not written and the word counter is not advanced for it.
- FSM:
  - IDLE: start=1 -> LOAD; set busy, clear done/overrun/counters. start is ignored when not in IDLE.
  - LOAD: pending=1 -> SETUP. Drive addr = BASE_ADDR + word_cnt (mod 16), din = holding register, cs=1, we=0; clear pending.
  - SETUP (1 cycle): addr/din/cs stable -> WRITE; set we=1.
  - WRITE (1 cycle): we=1 -> HOLD; set we=0, keep addr/din/cs.
  - HOLD (1 cycle): set cs=0 and increment word_cnt. If word_cnt+1 == NUM_WORDS -> DONE, else -> LOAD.
  - DONE: busy=0, done=1, cs=we=0 -> IDLE in the next cycle. addr/din keep their last values.
- we is high for exactly one cycle per word. addr/din are stable ≥1 cycle before we rises and ≥1 cycle after we falls (gated-clock safe for the store).
- cs and we are never both high outside WRITE. cs is never high while addr changes.
- A word can be written 3 cycles after pending is set, at the earliest. Each word takes 4 cycles (LOAD..HOLD) once pending.
- Words of a load are written in arrival order, consecutive addresses. BASE_ADDR+NUM_WORDS > 16 wraps modulo 16.
- A completed word arriving in DONE/IDLE is discarded. The shifter is cleared on an accepted start.
- rst asserted mid-write: we/cs drop asynchronously and the load is abandoned. No partial state survives.
- start and a completing word in the same cycle in IDLE: start is accepted and the word is discarded.

Test Plan:
- Reset: assert rst mid-sequence -> cs=we=busy=done=overrun=0, addr=0, din=0 immediately, before the next clock edge.
- Nominal load: start, then stream 0x1234, 0xABCD, 0x0F0F, 0x8001 with continuous sdi_valid.
  - Expect writes addr 7=0x1234, 8=0xABCD, 9=0x0F0F, A=0x8001.
  - Each write: we high 1 cycle, addr/din stable 1 cycle either side.
  - After the last HOLD: done=1, busy=0.
- Gapped stream: sdi_valid at a 1-in-5 duty -> same four writes, no overrun, we pulses separated by ≥76 cycles.
- Overrun: NUM_WORDS=4, words arrive with pending still set.
  - Example: two completions within 2 cycles in a 1-bit test build, or by forcing the holding path.
  - Expect overrun=1; the second word is written in place of the first; the word count is unaffected.
- Wrap: BASE_ADDR=4'hE, NUM_WORDS=3, data 0x1111, 0x2222, 0x3333 -> writes to addr E, F, 0.
- Spurious start while busy, and bits before start -> ignored; the load result is identical to the nominal case, and done clears on a new start.
